// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared state encoding and reset/bubble defaults for the instruction fetch sequencer.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_sequencer_skid.sv
// fetch_skid_reg: one-entry {pc, inst, valid} holding register used while decode stalls a returned fetch.
module fetch_skid_reg
    import fetch_sequencer_pkg::*;
#(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [INST_WIDTH-1:0] NOP_INST = INST_WIDTH'(DEF_NOP_INST)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  unload_i,
    input  logic                  clear_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic [INST_WIDTH-1:0] inst_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic                  valid_o
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [INST_WIDTH-1:0] inst_q;
    logic                  valid_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (load_i) begin
            pc_q    <= pc_i;
            inst_q  <= inst_i;
            valid_q <= 1'b1;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end
    end

    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, issues single-outstanding imem requests, fills IF/ID and applies branch redirects.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int INST_WIDTH      = 32,
    parameter int INST_ADDR_WIDTH = 32,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = INST_ADDR_WIDTH'(DEF_RESET_PC),
    parameter logic [INST_WIDTH-1:0]      NOP_INST = INST_WIDTH'(DEF_NOP_INST),
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stall_ID,
    output logic                       imem_req,
    output logic [INST_ADDR_WIDTH-1:0] imem_addr,
    input  logic                       imem_ack,
    input  logic                       imem_rvalid,
    input  logic [INST_WIDTH-1:0]      imem_rdata,
    input  logic                       branch_taken,
    input  logic                       branch_source,
    input  logic [INST_ADDR_WIDTH-1:0] branch_jalr_target,
    input  logic [INST_ADDR_WIDTH-1:0] branch_jal_beq_bne_target,
    output logic [INST_ADDR_WIDTH-1:0] PC_IF_ID,
    output logic [INST_WIDTH-1:0]      inst_IF_ID,
    output logic                       valid_IF_ID,
    output logic [CNT_WIDTH-1:0]       redirect_cnt
);

    localparam int AW = INST_ADDR_WIDTH;
    localparam int IW = INST_WIDTH;
    localparam logic [AW-1:0] PC_STEP = AW'(4);

    fetch_state_e   state_q;
    logic [AW-1:0]  pc_q;
    logic [AW-1:0]  req_pc_q;
    logic           drop_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [AW-1:0]  if_pc_q;
    logic [IW-1:0]  if_inst_q;
    logic           if_valid_q;

    logic           redirect;
    logic           req_fire;
    logic           take_resp;
    logic           redir_pending;
    logic [AW-1:0]  target;
    logic           skid_load;
    logic           skid_unload;
    logic           skid_clear;
    logic [AW-1:0]  skid_pc;
    logic [IW-1:0]  skid_inst;
    logic           skid_valid;

    always_comb begin
        target        = branch_source ? branch_jalr_target : branch_jal_beq_bne_target;
        target[1:0]   = 2'b00;
        redirect      = start && branch_taken && if_valid_q && !stall_ID;
        imem_req      = start && !stall_ID && state_q == ST_REQ;
        req_fire      = imem_req && imem_ack;
        take_resp     = state_q == ST_WAIT && imem_rvalid && !drop_q;
        // A redirect leaves a request in flight if it was just accepted or is still awaiting data.
        redir_pending = req_fire || (state_q == ST_WAIT && !imem_rvalid);
        skid_load     = start && !redirect && take_resp && stall_ID;
        skid_unload   = start && state_q == ST_HOLD && !stall_ID;
        skid_clear    = !start || redirect;
    end

    fetch_skid_reg #(
        .INST_WIDTH (IW),
        .ADDR_WIDTH (AW),
        .NOP_INST   (NOP_INST)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .pc_i     (req_pc_q),
        .inst_i   (imem_rdata),
        .pc_o     (skid_pc),
        .inst_o   (skid_inst),
        .valid_o  (skid_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            drop_q     <= 1'b0;
            cnt_q      <= '0;
            if_pc_q    <= '0;
            if_inst_q  <= NOP_INST;
            if_valid_q <= 1'b0;
        end else if (!start) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            drop_q     <= (drop_q || state_q == ST_WAIT) && !imem_rvalid;
            if_inst_q  <= NOP_INST;
            if_valid_q <= 1'b0;
        end else if (redirect) begin
            pc_q       <= target;
            if_inst_q  <= NOP_INST;
            if_valid_q <= 1'b0;
            cnt_q      <= (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
            drop_q     <= redir_pending;
            state_q    <= redir_pending ? ST_WAIT : ST_REQ;
        end else begin
            // Decode consumes IF/ID every unstalled cycle; a bubble follows unless new data lands below.
            if (!stall_ID) begin
                if_inst_q  <= NOP_INST;
                if_valid_q <= 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    drop_q  <= drop_q && !imem_rvalid;
                    state_q <= (drop_q && !imem_rvalid) ? ST_WAIT : ST_REQ;
                end
                ST_REQ: if (req_fire) begin
                    req_pc_q <= pc_q;
                    pc_q     <= pc_q + PC_STEP;
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: if (imem_rvalid) begin
                    drop_q  <= 1'b0;
                    state_q <= (drop_q || !stall_ID) ? ST_REQ : ST_HOLD;
                    if (!drop_q && !stall_ID) begin
                        if_pc_q    <= req_pc_q;
                        if_inst_q  <= imem_rdata;
                        if_valid_q <= 1'b1;
                    end
                end
                ST_HOLD: if (!stall_ID) begin
                    if_pc_q    <= skid_pc;
                    if_inst_q  <= skid_inst;
                    if_valid_q <= skid_valid;
                    state_q    <= ST_REQ;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign imem_addr    = pc_q;
    assign PC_IF_ID     = if_pc_q;
    assign inst_IF_ID   = if_inst_q;
    assign valid_IF_ID  = if_valid_q;
    assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed per-cycle vector table plus redirect-saturation and mid-run reset sequences.
module tb_fetch_sequencer;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst, start, stall_ID, imem_req, imem_ack, imem_rvalid;
    logic        branch_taken, branch_source, valid_IF_ID;
    logic [31:0] imem_addr, imem_rdata, jalr_t, jal_t, PC_IF_ID, inst_IF_ID;
    logic [3:0]  redirect_cnt;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.CNT_WIDTH(4)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .stall_ID                  (stall_ID),
        .imem_req                  (imem_req),
        .imem_addr                 (imem_addr),
        .imem_ack                  (imem_ack),
        .imem_rvalid               (imem_rvalid),
        .imem_rdata                (imem_rdata),
        .branch_taken              (branch_taken),
        .branch_source             (branch_source),
        .branch_jalr_target        (jalr_t),
        .branch_jal_beq_bne_target (jal_t),
        .PC_IF_ID                  (PC_IF_ID),
        .inst_IF_ID                (inst_IF_ID),
        .valid_IF_ID               (valid_IF_ID),
        .redirect_cnt              (redirect_cnt)
    );

    typedef struct {
        logic        st, stl, ack, rv;
        logic [31:0] rdata;
        logic        bt, bs;
        logic        ereq;
        logic [31:0] eaddr, epc, einst;
        logic        evld;
        logic [3:0]  ecnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic st, stl, ack, rv, input logic [31:0] rdata,
                               input logic bt, bs, ereq, input logic [31:0] eaddr, epc, einst,
                               input logic evld, input logic [3:0] ecnt);
        vec_t r;
        r = '{st, stl, ack, rv, rdata, bt, bs, ereq, eaddr, epc, einst, evld, ecnt};
        return r;
    endfunction

    function automatic logic [31:0] ins(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic drive(input logic st, stl, ack, rv, input logic [31:0] rd, input logic bt, bs);
        start = st; stall_ID = stl; imem_ack = ack; imem_rvalid = rv;
        imem_rdata = rd; branch_taken = bt; branch_source = bs;
    endtask

    initial begin
        jalr_t = 32'h0000_0103;
        jal_t  = 32'h0000_0043;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        // fetch 0,4,8 back to back with 1-cycle memory latency
        vq.push_back(v(0,0,0,0,0,0,0,        0,32'h00, 32'h00, NOP,       0,0));
        vq.push_back(v(1,0,0,0,0,0,0,        0,32'h00, 32'h00, NOP,       0,0));
        vq.push_back(v(1,0,1,0,0,0,0,        1,32'h00, 32'h00, NOP,       0,0));
        vq.push_back(v(1,0,0,1,ins(0),0,0,   0,32'h04, 32'h00, NOP,       0,0));
        vq.push_back(v(1,0,1,0,0,0,0,        1,32'h04, 32'h00, ins(0),    1,0));
        vq.push_back(v(1,0,0,1,ins(4),0,0,   0,32'h08, 32'h00, NOP,       0,0));
        vq.push_back(v(1,0,1,0,0,0,0,        1,32'h08, 32'h04, ins(4),    1,0));
        vq.push_back(v(1,0,0,1,ins(8),0,0,   0,32'h0C, 32'h04, NOP,       0,0));
        // jal at 0x8 while the request to 0xC is acked: 0xC dropped, fetch 0x40
        vq.push_back(v(1,0,1,0,0,1,0,        1,32'h0C, 32'h08, ins(8),    1,0));
        vq.push_back(v(1,0,0,1,JUNK,0,0,     0,32'h40, 32'h08, NOP,       0,1));
        vq.push_back(v(1,0,1,0,0,0,0,        1,32'h40, 32'h08, NOP,       0,1));
        vq.push_back(v(1,0,0,1,ins(32'h40),0,0, 0,32'h44, 32'h08, NOP,    0,1));
        vq.push_back(v(1,0,1,0,0,0,0,        1,32'h44, 32'h40, ins(32'h40),1,1));
        // stall for 3 cycles while 0x44 returns: parked, then released intact
        vq.push_back(v(1,1,0,1,ins(32'h44),0,0, 0,32'h48, 32'h40, NOP,    0,1));
        vq.push_back(v(1,1,0,0,0,0,0,        0,32'h48, 32'h40, NOP,       0,1));
        vq.push_back(v(1,1,0,0,0,0,0,        0,32'h48, 32'h40, NOP,       0,1));
        vq.push_back(v(1,0,0,0,0,0,0,        0,32'h48, 32'h40, NOP,       0,1));
        vq.push_back(v(1,1,0,0,0,0,0,        0,32'h48, 32'h44, ins(32'h44),1,1));
        vq.push_back(v(1,1,0,0,0,1,0,        0,32'h48, 32'h44, ins(32'h44),1,1));
        vq.push_back(v(1,0,1,0,0,0,0,        1,32'h48, 32'h44, ins(32'h44),1,1));
        vq.push_back(v(1,0,0,1,ins(32'h48),0,0, 0,32'h4C, 32'h44, NOP,    0,1));
        // jalr (0x103 -> 0x100) while the request to 0x4C is acked
        vq.push_back(v(1,0,1,0,0,1,1,        1,32'h4C, 32'h48, ins(32'h48),1,1));
        vq.push_back(v(1,0,0,1,JUNK,0,0,     0,32'h100,32'h48, NOP,       0,2));
        vq.push_back(v(1,0,1,0,0,0,0,        1,32'h100,32'h48, NOP,       0,2));
        vq.push_back(v(1,0,0,1,ins(32'h100),0,0, 0,32'h104,32'h48, NOP,   0,2));
        vq.push_back(v(1,0,0,0,0,0,0,        1,32'h104,32'h100,ins(32'h100),1,2));
        vq.push_back(v(1,0,1,0,0,0,0,        1,32'h104,32'h100,NOP,       0,2));
        // start dropped mid-WAIT, restarted: stale response discarded, fetch from 0
        vq.push_back(v(0,0,0,0,0,0,0,        0,32'h108,32'h100,NOP,       0,2));
        vq.push_back(v(0,0,0,0,0,0,0,        0,32'h00, 32'h100,NOP,       0,2));
        vq.push_back(v(1,0,0,0,0,0,0,        0,32'h00, 32'h100,NOP,       0,2));
        vq.push_back(v(1,0,0,1,JUNK,0,0,     0,32'h00, 32'h100,NOP,       0,2));
        vq.push_back(v(1,0,1,0,0,0,0,        1,32'h00, 32'h100,NOP,       0,2));
        vq.push_back(v(1,0,0,1,32'hB000_0000,0,0, 0,32'h04, 32'h100,NOP,  0,2));
        vq.push_back(v(1,0,0,0,0,0,0,        1,32'h04, 32'h00, 32'hB000_0000,1,2));
        // branch_taken with an empty IF/ID is ignored
        vq.push_back(v(1,0,0,0,0,1,0,        1,32'h04, 32'h00, NOP,       0,2));
        vq.push_back(v(0,0,0,0,0,0,0,        0,32'h04, 32'h00, NOP,       0,2));
        vq.push_back(v(0,0,0,0,0,0,0,        0,32'h00, 32'h00, NOP,       0,2));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vq.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vq[i].st, vq[i].stl, vq[i].ack, vq[i].rv, vq[i].rdata, vq[i].bt, vq[i].bs);
            #1;
            chk($sformatf("row%0d imem_req", i), imem_req, vq[i].ereq);
            chk($sformatf("row%0d imem_addr", i), imem_addr, vq[i].eaddr);
            chk($sformatf("row%0d PC_IF_ID", i), PC_IF_ID, vq[i].epc);
            chk($sformatf("row%0d inst_IF_ID", i), inst_IF_ID, vq[i].einst);
            chk($sformatf("row%0d valid_IF_ID", i), valid_IF_ID, vq[i].evld);
            chk($sformatf("row%0d redirect_cnt", i), redirect_cnt, vq[i].ecnt);
        end
        // 17 more redirects (19 total) must saturate the 4-bit counter at 4'hF
        @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk); drive(1, 0, 1, 0, 0, 0, 0);
            @(negedge clk); drive(1, 0, 0, 1, ins(i), 0, 0);
            @(negedge clk); drive(1, 0, 0, 0, 0, 1, 0);
            @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0);
            #1;
            chk($sformatf("sat%0d redirect_cnt", i), redirect_cnt, (3 + i > 15) ? 32'd15 : 32'(3 + i));
            chk($sformatf("sat%0d imem_addr", i), imem_addr, 32'h40);
            chk($sformatf("sat%0d valid_IF_ID", i), valid_IF_ID, 1'b0);
        end
        // synchronous reset in the middle of a run
        @(negedge clk); drive(1, 0, 1, 0, 0, 0, 0);
        @(negedge clk); drive(1, 0, 0, 1, 32'h0000_C0DE, 0, 0);
        @(negedge clk); drive(1, 1, 0, 0, 0, 0, 0);
        #1;
        chk("prerst PC_IF_ID", PC_IF_ID, 32'h40);
        chk("prerst inst_IF_ID", inst_IF_ID, 32'h0000_C0DE);
        chk("prerst valid_IF_ID", valid_IF_ID, 1'b1);
        rst = 1'b1;
        @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst imem_req", imem_req, 1'b0);
        chk("rst imem_addr", imem_addr, 32'h0);
        chk("rst PC_IF_ID", PC_IF_ID, 32'h0);
        chk("rst inst_IF_ID", inst_IF_ID, NOP);
        chk("rst valid_IF_ID", valid_IF_ID, 1'b0);
        chk("rst redirect_cnt", redirect_cnt, 4'h0);
        rst = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
